iomem_rr_arbiter: RTL and testbench
===================================

IOMEM_RR_ARBITER -- requirements
Module: iomem_rr_arbiter

Interface
REQ-001 SHALL have parameter RAM_DELAY, default 16, cycles from grant to response (legal range 2..255).
REQ-002 SHALL have parameter RAM_BASE_ADDR, default 32'h4000_0000, RAM window base.
REQ-003 SHALL have parameter RAM_MASK_ADDR, default 32'h000f_ffff, RAM window offset mask.
REQ-004 SHALL have port clk_i  input  1  clock; reset rst_n, synchronous, active-low; clock clk_i.
REQ-005 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-006 SHALL have ports m0_valid/m1_valid  input  1  requester transaction request.
REQ-007 SHALL have ports m0_ready/m1_ready  output  1  one-cycle completion pulse.
REQ-008 SHALL have ports m0_wstrb/m1_wstrb  input  4  byte write strobes; 0 means read.
REQ-009 SHALL have ports m0_addr/m1_addr, m0_wdata/m1_wdata  input  32  byte address, write data.
REQ-010 SHALL have ports m0_rdata/m1_rdata  output  32  read data, valid with ready.
REQ-011 SHALL have ports mem_addr, mem_wdata  output  32  RAM address and write data.
REQ-012 SHALL have ports mem_wr_strb  output  4, and mem_rd_en  output  1  RAM access strobes.
REQ-013 SHALL have port mem_rdata  input  32  RAM read data, valid one cycle after mem_rd_en and held until the next access.
REQ-014 SHALL have port grant_o  output  2  one-hot current owner; 2'b00 when idle.

Function
REQ-015 SHALL implement FSM IDLE -> ACCESS -> WAIT -> RESP -> IDLE.
REQ-016 In IDLE, any valid requester SHALL be granted in that cycle; state moves to ACCESS next cycle.
REQ-017 Simultaneous valids SHALL be resolved round-robin: the requester not granted last wins; after reset m0 wins first.
REQ-018 At grant, addr, wdata, wstrb and owner SHALL be registered; later changes on requester inputs are ignored until RESP.
REQ-019 In-window test: (addr & ~RAM_MASK_ADDR) == RAM_BASE_ADDR.
REQ-020 ACCESS (exactly one cycle), in-window: mem_wr_strb = latched wstrb; mem_rd_en = 1 iff wstrb == 0; mem_addr/mem_wdata driven from latched values through RESP.
REQ-021 Strobes SHALL be 0 in every other state and for out-of-window transactions.
REQ-022 WAIT SHALL last RAM_DELAY-1 cycles counted by an 8-bit down-counter; RESP SHALL fall exactly RAM_DELAY cycles after ACCESS.
REQ-023 Latency: valid sampled in IDLE at cycle T -> ready pulse at cycle T+RAM_DELAY+1.
REQ-024 mem_rdata SHALL be registered on the final WAIT cycle; owner's rdata presents that register in RESP, 0 otherwise and for writes.
REQ-025 Out-of-window transaction: no RAM strobe, same timing, rdata = 32'h0.
REQ-026 RESP SHALL pulse only owner's ready for one cycle, update last-grant, return to IDLE; no grant in RESP cycle.
REQ-027 Valid deasserted mid-transaction SHALL NOT abort it; ready still pulses.
REQ-028 grant_o SHALL be one-hot from ACCESS through RESP inclusive.

Reset
REQ-029 While rst_n = 0 at a clock edge: state IDLE, counter 0, last-grant = m1, latches 0, rdata register 0.
REQ-030 Outputs in reset: m*_ready 0, m*_rdata 0, mem_wr_strb 0, mem_rd_en 0, mem_addr 0, mem_wdata 0, grant_o 0.
REQ-031 Reset mid-transaction SHALL abandon it with no ready pulse and no further RAM strobe.

Structure
REQ-032 Shared package iomem_pkg SHALL hold the FSM state type, RAM_BASE_ADDR/RAM_MASK_ADDR defaults and the in-window decode function.
REQ-033 Round-robin pick SHALL be sub-module iomem_rr_pick (two requests, last-grant in, one-hot grant out, combinational).

Verification
REQ-034 m0 read 32'h4000_0010 at T, RAM_DELAY=16 -> mem_rd_en only at T+1, mem_addr 32'h4000_0010, m0_ready at T+17, m0_rdata = RAM word.
REQ-035 m0 and m1 valid together from reset -> m0 served first, m1 granted the cycle after m0's RESP+1, ready 17 cycles later.
REQ-036 m1 write wstrb 4'b0011 data 32'hDEAD_BEEF -> mem_wr_strb 4'b0011 for one cycle, mem_rd_en 0, m1_rdata 0 at ready.
REQ-037 m0 read 32'h3000_0000 -> no RAM strobe, m0_ready at T+17, m0_rdata 32'h0.
REQ-038 rst_n low during WAIT -> no ready pulse, all outputs 0 next cycle; new m1 request after release is granted normally with full latency.

Source files
------------

// File: rtl/iomem_pkg.sv
// Shared types and helpers for the IO/memory round-robin arbiter.
// Holds the FSM state type, RAM window defaults and window decode.
package iomem_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [31:0] RAM_BASE_DEF = 32'h4000_0000;
  localparam logic [31:0] RAM_MASK_DEF = 32'h000f_ffff;

  function automatic logic in_window(
    input logic [31:0] addr,
    input logic [31:0] base,
    input logic [31:0] mask
  );
    return (addr & ~mask) == base;
  endfunction

endpackage

// File: rtl/iomem_rr_pick.sv
// Two-way round-robin picker, purely combinational.
// req0/req1 in, last_m1 = m1 granted last, gnt one-hot out ({m1,m0}).
module iomem_rr_pick (
  input  logic       req0,
  input  logic       req1,
  input  logic       last_m1,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    priority case (1'b1)
      (req0 & req1): gnt = last_m1 ? 2'b01 : 2'b10;
      req0:          gnt = 2'b01;
      req1:          gnt = 2'b10;
      default:       gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/iomem_rr_arbiter.sv
// Arbitrates two requesters onto one fixed-latency RAM port.
// Ports: clk_i, rst_n (sync, low); m0_*/m1_* requester side
// (valid, addr, wdata, wstrb in; ready, rdata out); mem_* RAM
// side (addr, wdata, wr_strb, rd_en out; rdata in); grant_o owner.
module iomem_rr_arbiter
  import iomem_pkg::*;
#(
  parameter int unsigned RAM_DELAY     = 16,
  parameter logic [31:0] RAM_BASE_ADDR = RAM_BASE_DEF,
  parameter logic [31:0] RAM_MASK_ADDR = RAM_MASK_DEF
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wr_strb,
  output logic        mem_rd_en,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  grant_o
);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q;
  logic        last_m1_q;
  logic        owner_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] rdata_q;
  logic [1:0]  gnt;
  logic        win;
  logic        busy;
  logic        hit;
  logic        resp;

  iomem_rr_pick u_pick (
    .req0    (m0_valid),
    .req1    (m1_valid),
    .last_m1 (last_m1_q),
    .gnt     (gnt)
  );

  assign win = in_window(addr_q, RAM_BASE_ADDR, RAM_MASK_ADDR);

  always_ff @(posedge clk_i) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (|gnt) state_d = S_ACCESS;
      S_ACCESS: state_d = S_WAIT;
      S_WAIT:   if (cnt_q == 8'd0) state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // WAIT spans RAM_DELAY-1 cycles: load RAM_DELAY-2, leave on zero.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      last_m1_q <= 1'b1;
      owner_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|gnt) begin
            owner_q <= gnt[1];
            addr_q  <= gnt[1] ? m1_addr  : m0_addr;
            wdata_q <= gnt[1] ? m1_wdata : m0_wdata;
            wstrb_q <= gnt[1] ? m1_wstrb : m0_wstrb;
          end
        end
        S_ACCESS: cnt_q <= 8'(RAM_DELAY - 2);
        S_WAIT: begin
          if (cnt_q == 8'd0) begin
            rdata_q <= (win && wstrb_q == 4'd0) ? mem_rdata : '0;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_RESP:  last_m1_q <= owner_q;
        default: ;
      endcase
    end
  end

  assign busy = (state_q != S_IDLE);
  assign hit  = (state_q == S_ACCESS) && win;
  assign resp = (state_q == S_RESP);

  assign grant_o     = busy ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign mem_addr    = busy ? addr_q  : '0;
  assign mem_wdata   = busy ? wdata_q : '0;
  assign mem_wr_strb = hit ? wstrb_q : 4'd0;
  assign mem_rd_en   = hit && (wstrb_q == 4'd0);

  assign m0_ready = resp && !owner_q;
  assign m1_ready = resp && owner_q;
  assign m0_rdata = m0_ready ? rdata_q : '0;
  assign m1_rdata = m1_ready ? rdata_q : '0;

endmodule

// File: tb/tb_iomem_rr_arbiter.sv
// Scoreboard bench for iomem_rr_arbiter with a 1-cycle RAM model.
// Stimulus pushes expected RAM strobes and ready pulses; monitors pop.
module tb_iomem_rr_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        m0_valid, m1_valid;
  logic        m0_ready, m1_ready;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wr_strb;
  logic        mem_rd_en;
  logic [31:0] mem_rdata = '0;
  logic [1:0]  grant_o;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    int          cyc;
    logic        m1;
    logic [31:0] rdata;
  } resp_t;

  typedef struct {
    int          cyc;
    logic        m1;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        rd;
  } mem_t;

  resp_t resp_q[$];
  mem_t  mem_q[$];

  iomem_rr_arbiter dut (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .m0_valid    (m0_valid),
    .m0_ready    (m0_ready),
    .m0_wstrb    (m0_wstrb),
    .m0_addr     (m0_addr),
    .m0_wdata    (m0_wdata),
    .m0_rdata    (m0_rdata),
    .m1_valid    (m1_valid),
    .m1_ready    (m1_ready),
    .m1_wstrb    (m1_wstrb),
    .m1_addr     (m1_addr),
    .m1_wdata    (m1_wdata),
    .m1_rdata    (m1_rdata),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wr_strb (mem_wr_strb),
    .mem_rd_en   (mem_rd_en),
    .mem_rdata   (mem_rdata),
    .grant_o     (grant_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // RAM word pattern: {addr[15:0], ~addr[15:0]}
  always @(posedge clk_i) begin
    if (mem_rd_en) mem_rdata <= {mem_addr[15:0], ~mem_addr[15:0]};
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (cyc %0d)",
                  nm, act, exp, cyc);
  endtask

  task automatic drive(input bit m1, input bit v,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [3:0] s);
    if (m1) begin
      m1_valid = v; m1_addr = a; m1_wdata = d; m1_wstrb = s;
    end else begin
      m0_valid = v; m0_addr = a; m0_wdata = d; m0_wstrb = s;
    end
  endtask

  task automatic exp_mem(input int c, input bit m1,
                         input logic [31:0] a,
                         input logic [31:0] d,
                         input logic [3:0] s, input bit rd);
    mem_t e;
    e.cyc = c; e.m1 = m1; e.addr = a;
    e.wdata = d; e.strb = s; e.rd = rd;
    mem_q.push_back(e);
  endtask

  task automatic exp_resp(input int c, input bit m1,
                          input logic [31:0] r);
    resp_t e;
    e.cyc = c; e.m1 = m1; e.rdata = r;
    resp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk_i);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_m0_ready"}, 32'(m0_ready), 32'd0);
    chk({tag, "_m1_ready"}, 32'(m1_ready), 32'd0);
    chk({tag, "_m0_rdata"}, m0_rdata, 32'd0);
    chk({tag, "_m1_rdata"}, m1_rdata, 32'd0);
    chk({tag, "_wr_strb"}, 32'(mem_wr_strb), 32'd0);
    chk({tag, "_rd_en"}, 32'(mem_rd_en), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_grant"}, 32'(grant_o), 32'd0);
  endtask

  // Ready monitor
  always @(negedge clk_i) begin
    resp_t r;
    if (m0_ready || m1_ready) begin
      if (resp_q.size() == 0) begin
        chk("unexpected_ready", 32'({m1_ready, m0_ready}), 32'd0);
      end else begin
        r = resp_q.pop_front();
        chk("ready_cyc", 32'(cyc), 32'(r.cyc));
        chk("ready_owner", 32'({m1_ready, m0_ready}),
            r.m1 ? 32'd2 : 32'd1);
        chk("ready_rdata", r.m1 ? m1_rdata : m0_rdata, r.rdata);
        chk("other_rdata", r.m1 ? m0_rdata : m1_rdata, 32'd0);
        chk("resp_grant", 32'(grant_o), r.m1 ? 32'd2 : 32'd1);
      end
    end
  end

  // RAM strobe monitor
  always @(negedge clk_i) begin
    mem_t m;
    if (mem_rd_en || mem_wr_strb != 4'd0) begin
      if (mem_q.size() == 0) begin
        chk("unexpected_strobe",
            32'({mem_wr_strb, mem_rd_en}), 32'd0);
      end else begin
        m = mem_q.pop_front();
        chk("mem_cyc", 32'(cyc), 32'(m.cyc));
        chk("mem_addr", mem_addr, m.addr);
        chk("mem_wdata", mem_wdata, m.wdata);
        chk("mem_wr_strb", 32'(mem_wr_strb), 32'(m.strb));
        chk("mem_rd_en", 32'(mem_rd_en), 32'(m.rd));
        chk("mem_grant", 32'(grant_o), m.m1 ? 32'd2 : 32'd1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_n = 1'b0;
    drive(0, 0, '0, '0, '0);
    drive(1, 0, '0, '0, '0);
    repeat (3) @(negedge clk_i);
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk_i);

    // m0 read in window; inputs scrambled after grant
    t = cyc;
    drive(0, 1, 32'h4000_0010, 32'h1111_2222, 4'd0);
    exp_mem(t + 1, 0, 32'h4000_0010, 32'h1111_2222, 4'd0, 1);
    exp_resp(t + 17, 0, 32'h0010_FFEF);
    @(negedge clk_i);
    drive(0, 0, 32'h4000_0FFC, 32'h9999_9999, 4'hF);
    wait_cyc(t + 20);

    // fresh reset so m0 wins the tie
    rst_n = 1'b0;
    @(negedge clk_i);
    rst_n = 1'b1;
    @(negedge clk_i);

    // simultaneous requests
    t = cyc;
    drive(0, 1, 32'h4000_0100, 32'd0, 4'd0);
    drive(1, 1, 32'h4000_0204, 32'd0, 4'd0);
    exp_mem(t + 1, 0, 32'h4000_0100, 32'd0, 4'd0, 1);
    exp_resp(t + 17, 0, 32'h0100_FEFF);
    exp_mem(t + 19, 1, 32'h4000_0204, 32'd0, 4'd0, 1);
    exp_resp(t + 35, 1, 32'h0204_FDFB);
    @(negedge clk_i);
    drive(0, 0, 32'd0, 32'd0, 4'd0);
    wait_cyc(t + 19);
    drive(1, 0, 32'd0, 32'd0, 4'd0);
    wait_cyc(t + 38);

    // m1 partial write
    t = cyc;
    drive(1, 1, 32'h4000_0008, 32'hDEAD_BEEF, 4'b0011);
    exp_mem(t + 1, 1, 32'h4000_0008, 32'hDEAD_BEEF, 4'b0011, 0);
    exp_resp(t + 17, 1, 32'd0);
    @(negedge clk_i);
    drive(1, 0, 32'd0, 32'd0, 4'd0);
    wait_cyc(t + 20);

    // m0 read outside window
    t = cyc;
    drive(0, 1, 32'h3000_0000, 32'd0, 4'd0);
    exp_resp(t + 17, 0, 32'd0);
    @(negedge clk_i);
    drive(0, 0, 32'd0, 32'd0, 4'd0);
    wait_cyc(t + 20);

    // reset during WAIT abandons the transaction
    t = cyc;
    drive(0, 1, 32'h4000_0020, 32'd0, 4'd0);
    exp_mem(t + 1, 0, 32'h4000_0020, 32'd0, 4'd0, 1);
    @(negedge clk_i);
    drive(0, 0, 32'd0, 32'd0, 4'd0);
    wait_cyc(t + 5);
    rst_n = 1'b0;
    @(negedge clk_i);
    check_idle("midreset");
    rst_n = 1'b1;
    t = cyc;
    drive(1, 1, 32'h4000_0040, 32'd0, 4'd0);
    exp_mem(t + 1, 1, 32'h4000_0040, 32'd0, 4'd0, 1);
    exp_resp(t + 17, 1, 32'h0040_FFBF);
    @(negedge clk_i);
    drive(1, 0, 32'd0, 32'd0, 4'd0);
    wait_cyc(t + 25);

    chk("resp_q_drained", 32'(resp_q.size()), 32'd0);
    chk("mem_q_drained", 32'(mem_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
